// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave front-end on the system clock; deserialises cmd+payload frames, serialises read data.
// Optional even-parity trailing bit enabled by defining SPI_SLAVE_PARITY_EN.
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int LSB_FIRST   = 0,
    parameter int TX_WAIT_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              busy,
    output logic              err
);
    localparam int FRAME_W = DATA_W + 2;
`ifdef SPI_SLAVE_PARITY_EN
    localparam int LAST = FRAME_W;
`else
    localparam int LAST = FRAME_W - 1;
`endif
    localparam int CW = $clog2(FRAME_W + 2);
    localparam int TW = $clog2(TX_WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    typedef enum logic [1:0] {P_RX, P_WAIT, P_SHIFT, P_HOLD} phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [1:0]          cmd_q, cmd_d, cmd_nx;
    logic [DATA_W-1:0]   pay_q, pay_d, pay_nx;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [FRAME_W-1:0]  rx_data_q, rx_data_d, frame;
    logic                rx_valid_q, rx_valid_d;
    logic                err_q, err_d;
    logic                miso_q, miso_d;
    logic                rd_addr_seen_q, rd_addr_seen_d;
    logic                par_ok;

    always_comb begin
        cmd_nx = cnt_q < CW'(2) ? {cmd_q[0], MOSI} : cmd_q;
        pay_nx = pay_q;
        if (cnt_q >= CW'(2) && cnt_q < CW'(FRAME_W))
            pay_nx = LSB_FIRST != 0 ? {MOSI, pay_q[DATA_W-1:1]} : {pay_q[DATA_W-2:0], MOSI};
`ifdef SPI_SLAVE_PARITY_EN
        frame  = {cmd_q, pay_q};
        par_ok = MOSI == ^frame;
`else
        frame  = {cmd_nx, pay_nx};
        par_ok = 1'b1;
`endif
        state_d        = state_q;
        phase_d        = phase_q;
        cnt_d          = cnt_q;
        tmo_d          = tmo_q;
        cmd_d          = cmd_q;
        pay_d          = pay_q;
        tx_d           = tx_q;
        rx_data_d      = rx_data_q;
        rd_addr_seen_d = rd_addr_seen_q;
        rx_valid_d     = 1'b0;
        err_d          = 1'b0;
        miso_d         = 1'b0;
        if (SS_n) begin
            state_d = IDLE;
            phase_d = P_RX;
            cnt_d   = '0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                IDLE: state_d = CHK_CMD;
                CHK_CMD: begin
                    state_d = !MOSI ? WRITE : rd_addr_seen_q ? READ_DATA : READ_ADD;
                    phase_d = P_RX;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end
                default: begin
                    case (phase_q)
                        P_RX: begin
                            cmd_d = cmd_nx;
                            pay_d = pay_nx;
                            cnt_d = cnt_q + 1'b1;
                            if (cnt_q == CW'(LAST)) begin
                                phase_d = P_HOLD;
                                err_d   = !par_ok;
                                if (par_ok) begin
                                    rx_data_d      = frame;
                                    rx_valid_d     = 1'b1;
                                    rd_addr_seen_d = state_q == READ_ADD ? 1'b1 :
                                                     state_q == READ_DATA ? 1'b0 : rd_addr_seen_q;
                                    phase_d        = state_q == READ_DATA ? P_WAIT : P_HOLD;
                                end
                            end
                        end
                        P_WAIT: begin
                            if (tx_valid) begin
                                tx_d    = tx_data;
                                phase_d = P_SHIFT;
                                cnt_d   = '0;
                            end else if (tmo_q == TW'(TX_WAIT_MAX - 1)) begin
                                err_d   = 1'b1;
                                phase_d = P_HOLD;
                            end else begin
                                tmo_d = tmo_q + 1'b1;
                            end
                        end
                        P_SHIFT: begin
                            miso_d  = LSB_FIRST != 0 ? tx_q[0] : tx_q[DATA_W-1];
                            tx_d    = LSB_FIRST != 0 ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
                            cnt_d   = cnt_q + 1'b1;
                            phase_d = cnt_q == CW'(DATA_W - 1) ? P_HOLD : P_SHIFT;
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            phase_q        <= P_RX;
            cnt_q          <= '0;
            tmo_q          <= '0;
            cmd_q          <= '0;
            pay_q          <= '0;
            tx_q           <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            err_q          <= 1'b0;
            miso_q         <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            cmd_q          <= cmd_d;
            pay_q          <= pay_d;
            tx_q           <= tx_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            err_q          <= err_d;
            miso_q         <= miso_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err      = err_q;
    assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_spi_slave_param.sv
// tb_spi_slave_param: table-driven and scoreboarded bench for spi_slave_param (MSB-first and LSB-first instances).
module tb_spi_slave_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       miso_m, miso_l, rx_valid_m, rx_valid_l, busy_m, busy_l, err_m, err_l;
    logic [9:0] rx_data_m, rx_data_l;

    int n_chk = 0;
    int n_pass = 0;
    int err_cnt_m = 0;
    int err_cnt_l = 0;
    logic [9:0] q_m[$];
    logic [9:0] q_l[$];
    logic [9:0] last_m = '0;
    logic [9:0] last_l = '0;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8), .LSB_FIRST(0), .TX_WAIT_MAX(16)) dut_m (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_m),
        .rx_data(rx_data_m), .rx_valid(rx_valid_m), .tx_data(tx_data),
        .tx_valid(tx_valid), .busy(busy_m), .err(err_m)
    );

    spi_slave_param #(.DATA_W(8), .LSB_FIRST(1), .TX_WAIT_MAX(16)) dut_l (
        .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso_l),
        .rx_data(rx_data_l), .rx_valid(rx_valid_l), .tx_data(tx_data),
        .tx_valid(tx_valid), .busy(busy_l), .err(err_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rx_valid strobe must match the oldest expected frame.
    always @(negedge clk) begin
        if (rx_valid_m === 1'b1) begin
            if (q_m.size() == 0) check("rx_m_unexpected", 32'(rx_data_m), 32'h7fff);
            else check("rx_m", 32'(rx_data_m), 32'(q_m.pop_front()));
        end
        if (rx_valid_l === 1'b1) begin
            if (q_l.size() == 0) check("rx_l_unexpected", 32'(rx_data_l), 32'h7fff);
            else check("rx_l", 32'(rx_data_l), 32'(q_l.pop_front()));
        end
        if (err_m === 1'b1) err_cnt_m++;
        if (err_l === 1'b1) err_cnt_l++;
    end

    task automatic send_frame(input logic chk, input logic [9:0] f, input bit bad);
        SS_n = 1'b0;
        tick();
        MOSI = chk;
        tick();
        for (int i = 9; i >= 0; i--) begin
            MOSI = f[i];
`ifndef SPI_SLAVE_PARITY_EN
            if (i == 0 && !bad) begin
                q_m.push_back(f);
                q_l.push_back({f[9:8], rev8(f[7:0])});
            end
`endif
            tick();
        end
`ifdef SPI_SLAVE_PARITY_EN
        MOSI = (^f) ^ bad;
        if (!bad) begin
            q_m.push_back(f);
            q_l.push_back({f[9:8], rev8(f[7:0])});
        end
        tick();
`endif
        if (!bad) begin
            last_m = f;
            last_l = {f[9:8], rev8(f[7:0])};
        end
        MOSI = 1'b0;
    endtask

    task automatic end_frame;
        SS_n = 1'b1;
        tick();
        check("busy_after_release", 32'({busy_m, busy_l}), 32'h0);
    endtask

    task automatic read_out(input logic [7:0] td, input int delay);
        for (int d = 1; d < delay; d++) begin
            tick();
            check("miso_wait", 32'({miso_m, miso_l}), 32'h0);
        end
        tx_data  = td;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("miso_latch", 32'({miso_m, miso_l}), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("miso_m_bit", 32'(miso_m), 32'(td[7-i]));
            check("miso_l_bit", 32'(miso_l), 32'(td[i]));
        end
        tick();
        check("miso_after", 32'({miso_m, miso_l, err_m, err_l}), 32'h0);
    endtask

    typedef struct {
        logic       chk;
        logic [9:0] frame;
        logic [9:0] exp_m;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b0, 10'h005, 10'h005};
        vecs[1] = '{1'b0, 10'h1FF, 10'h1FF};
        vecs[2] = '{1'b0, 10'h0A3, 10'h0A3};
        vecs[3] = '{1'b0, 10'h3C1, 10'h3C1};

        tick();
        tick();
        rst = 1'b0;
        check("reset_outs", 32'({miso_m, rx_valid_m, busy_m, err_m, miso_l, rx_valid_l, busy_l, err_l}), 32'h0);
        check("reset_rx", 32'({rx_data_m, rx_data_l}), 32'h0);

        foreach (vecs[k]) begin
            send_frame(vecs[k].chk, vecs[k].frame, 1'b0);
            check("wr_valid", 32'({rx_valid_m, rx_valid_l}), 32'h3);
            check("wr_miso", 32'({miso_m, miso_l}), 32'h0);
            tick();
            check("wr_valid_drop", 32'({rx_valid_m, rx_valid_l}), 32'h0);
            check("wr_busy_hold", 32'({busy_m, busy_l}), 32'h3);
            end_frame();
            check("wr_rx_hold", 32'(rx_data_m), 32'(vecs[k].exp_m));
        end

        // Read address, then read data answered three cycles after rx_valid.
        send_frame(1'b1, 10'h203, 1'b0);
        check("ra_rx", 32'(rx_data_m), 32'h203);
        end_frame();
        send_frame(1'b1, 10'h3C4, 1'b0);
        read_out(8'hA5, 3);
        end_frame();

        // rd_addr_seen cleared: a read frame now goes to READ_ADD and never shifts out.
        send_frame(1'b1, 10'h2F0, 1'b0);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        tick();
        tick();
        tx_valid = 1'b0;
        check("ra_ignores_tx", 32'({miso_m, miso_l}), 32'h0);
        end_frame();

        // Timeout with no tx_valid.
        send_frame(1'b1, 10'h3AA, 1'b0);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("tmo_pre", 32'({err_m, err_l, miso_m, miso_l}), 32'h0);
        end
        tick();
        check("tmo_err", 32'({err_m, err_l, miso_m, miso_l}), 32'hC);
        tick();
        check("tmo_err_drop", 32'({err_m, err_l}), 32'h0);
        tx_valid = 1'b1;
        tick();
        tick();
        tx_valid = 1'b0;
        check("tmo_no_shift", 32'({miso_m, miso_l}), 32'h0);
        end_frame();

        // Bit order on tx: 8'h01 immediately after rx_valid.
        send_frame(1'b1, 10'h211, 1'b0);
        end_frame();
        send_frame(1'b1, 10'h3FE, 1'b0);
        read_out(8'h01, 1);
        end_frame();

        // Abort after 5 payload bits.
        SS_n = 1'b0;
        tick();
        MOSI = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) begin
            MOSI = i[0];
            tick();
        end
        SS_n = 1'b1;
        tick();
        check("abort_busy", 32'({busy_m, busy_l, rx_valid_m, rx_valid_l}), 32'h0);
        check("abort_rx_m", 32'(rx_data_m), 32'(last_m));
        check("abort_rx_l", 32'(rx_data_l), 32'(last_l));

`ifdef SPI_SLAVE_PARITY_EN
        send_frame(1'b0, 10'h155, 1'b1);
        check("par_err", 32'({err_m, err_l, rx_valid_m, rx_valid_l}), 32'hC);
        check("par_rx_hold", 32'(rx_data_m), 32'(last_m));
        end_frame();
`endif

        // Reset mid-frame.
        SS_n = 1'b0;
        tick();
        MOSI = 1'b0;
        tick();
        MOSI = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_outs", 32'({miso_m, rx_valid_m, busy_m, err_m, miso_l, rx_valid_l, busy_l, err_l}), 32'h0);
        check("rst_mid_rx", 32'({rx_data_m, rx_data_l}), 32'h0);
        rst  = 1'b0;
        SS_n = 1'b1;
        tick();

`ifdef SPI_SLAVE_PARITY_EN
        check("err_total", 32'(err_cnt_m + err_cnt_l), 32'd4);
`else
        check("err_total", 32'(err_cnt_m + err_cnt_l), 32'd2);
`endif
        check("queues_drained", 32'(q_m.size() + q_l.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
